obstacle_field: RTL and testbench

Parametrised obstacle/lane engine for the crossy-road game. It replaces the fixed three-obstacle scroll and collision logic with NUM_LANES independent lanes that move in alternating directions, with speed that scales with score. It adds frame-synchronous position updates, a registered collision detector and a game-state FSM (PLAY / HIT / RESTART), so a collision no longer resets the game instantly. It sits between the VGA timing generator and the top-level RGB mux.

---
 rtl/crossy_pkg.sv | 27 ++
 rtl/obstacle_lane.sv | 69 ++++++
 rtl/obstacle_field.sv | 185 ++++++++++++++++++
 tb/tb_obstacle_field.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossy_pkg.sv
// Shared constants for the crossy-road video pipeline: screen size, chicken
// sprite geometry, game-state encodings and a span-test helper.
package crossy_pkg;

    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned COORD_W   = 10;

    // Chicken sprite is fixed on screen: x 310..339, y 400..439
    localparam int unsigned CHICKEN_X = 310;
    localparam int unsigned CHICKEN_W = 30;
    localparam int unsigned CHICKEN_Y = 400;
    localparam int unsigned CHICKEN_H = 40;

    // Game state encodings (also driven out on the state port)
    localparam logic [1:0] ST_PLAY    = 2'd0;
    localparam logic [1:0] ST_HIT     = 2'd1;
    localparam logic [1:0] ST_RESTART = 2'd2;

    // True when pos lies in [start, start+len); 11-bit sum so no wrap
    function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                     input logic [COORD_W-1:0] start,
                                     input logic [COORD_W:0]   len);
        return (11'(pos) >= 11'(start)) && (11'(pos) < (11'(start) + len));
    endfunction

endpackage

// File: rtl/obstacle_lane.sv
// One obstacle lane: x/y position registers with screen wrap, and the
// combinational "this pixel is inside my obstacle" test.
// Ports:
//   clk, reset   clock, async active-high reset (loads X_INIT/Y_INIT)
//   reload       synchronous reload of the initial position
//   step         advance x by speed this cycle (DIR 0 = right, 1 = left)
//   move         together with step, scroll y down by Y_STEP
//   speed        px per step
//   hpos, vpos   current pixel
//   hit_c        combinational: pixel is covered by this obstacle
module obstacle_lane
    import crossy_pkg::*;
#(
    parameter int unsigned DIR    = 0,
    parameter int unsigned X_INIT = 0,
    parameter int unsigned Y_INIT = 0,
    parameter int unsigned OB_W   = 50,
    parameter int unsigned OB_H   = 30,
    parameter int unsigned Y_STEP = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reload,
    input  logic                step,
    input  logic                move,
    input  logic [COORD_W-1:0]  speed,
    input  logic [COORD_W-1:0]  hpos,
    input  logic [COORD_W-1:0]  vpos,
    output logic                hit_c
);

    logic [COORD_W-1:0] x_pos;
    logic [COORD_W-1:0] y_pos;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic [COORD_W:0]   x_sum;
    logic [COORD_W:0]   y_sum;

    // Wrapped next positions and the pixel hit test
    always_comb begin
        x_sum = 11'(x_pos) + 11'(speed);
        y_sum = 11'(y_pos) + 11'(Y_STEP);
        if (DIR == 0) begin
            x_nxt = (x_sum >= 11'(H_ACTIVE)) ? 10'(x_sum - 11'(H_ACTIVE)) : 10'(x_sum);
        end else begin
            x_nxt = (x_pos < speed) ? 10'(11'(x_pos) + 11'(H_ACTIVE) - 11'(speed))
                                    : (x_pos - speed);
        end
        y_nxt = (y_sum >= 11'(V_ACTIVE)) ? 10'(y_sum - 11'(V_ACTIVE)) : 10'(y_sum);
        hit_c = in_span(hpos, x_pos, 11'(OB_W)) && in_span(vpos, y_pos, 11'(OB_H));
    end

    // Position registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_pos <= 10'(X_INIT);
            y_pos <= 10'(Y_INIT);
        end else if (reload) begin
            x_pos <= 10'(X_INIT);
            y_pos <= 10'(Y_INIT);
        end else if (step) begin
            x_pos <= x_nxt;
            if (move) begin
                y_pos <= y_nxt;
            end
        end
    end

endmodule

// File: rtl/obstacle_field.sv
// Obstacle/lane engine: NUM_LANES lanes in alternating directions, speed
// scaled by score, frame-synchronous updates, registered collision detect and
// the PLAY / HIT / RESTART game FSM.
// Ports:
//   clk, reset      clock, async active-high reset
//   frame_tick      one-cycle pulse at start of vblank
//   move_btn        raw asynchronous button
//   hpos, vpos      current pixel, display_on active-video flag
//   ob_pixel        registered: an obstacle covers the pixel
//   chicken_pixel   registered: the chicken covers the pixel
//   hit_flash       high while in HIT
//   collision       one-cycle pulse on entry to HIT
//   score           forward moves, saturating at 255
//   state           PLAY=0, HIT=1, RESTART=2
module obstacle_field
    import crossy_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned OB_W         = 50,
    parameter int unsigned OB_H         = 30,
    parameter int unsigned Y_START      = 32,
    parameter int unsigned LANE_PITCH   = 90,
    parameter int unsigned X_OFFSET     = 160,
    parameter int unsigned Y_STEP       = 10,
    parameter int unsigned BASE_SPEED   = 1,
    parameter int unsigned SPEED_SHIFT  = 3,
    parameter int unsigned MAX_SPEED    = 4,
    parameter int unsigned FLASH_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        move_btn,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    output logic        ob_pixel,
    output logic        chicken_pixel,
    output logic        hit_flash,
    output logic        collision,
    output logic [7:0]  score,
    output logic [1:0]  state
);

    localparam int unsigned CNT_W = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

    logic                 btn_s1;
    logic                 btn_s2;
    logic                 btn_d;
    logic                 btn_edge;
    logic                 move_pending;
    logic                 pending_nxt;
    logic                 hit_latch;
    logic                 latch_nxt;
    logic [CNT_W-1:0]     flash_cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [1:0]           state_nxt;
    logic [7:0]           score_nxt;
    logic                 lane_step;
    logic                 lane_move;
    logic                 lane_reload;
    logic                 enter_hit;
    logic [8:0]           speed_raw;
    logic [COORD_W-1:0]   speed;
    logic [NUM_LANES-1:0] lane_hit;
    logic                 chicken_hit;

    assign btn_edge = btn_s2 & ~btn_d;

    // Speed from the pre-increment score, capped
    assign speed_raw = 9'(BASE_SPEED) + 9'(score >> SPEED_SHIFT);
    assign speed     = (speed_raw > 9'(MAX_SPEED)) ? 10'(MAX_SPEED) : 10'(speed_raw);

    assign chicken_hit = in_span(hpos, 10'(CHICKEN_X), 11'(CHICKEN_W)) &&
                         in_span(vpos, 10'(CHICKEN_Y), 11'(CHICKEN_H));

    // Lanes: even lanes move right, odd lanes move left
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        obstacle_lane #(
            .DIR    (i % 2),
            .X_INIT ((i * X_OFFSET) % H_ACTIVE),
            .Y_INIT ((Y_START + i * LANE_PITCH) % V_ACTIVE),
            .OB_W   (OB_W),
            .OB_H   (OB_H),
            .Y_STEP (Y_STEP)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .reload (lane_reload),
            .step   (lane_step),
            .move   (lane_move),
            .speed  (speed),
            .hpos   (hpos),
            .vpos   (vpos),
            .hit_c  (lane_hit[i])
        );
    end

    // Game FSM next state, score, flags and lane controls
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = flash_cnt;
        score_nxt   = score;
        pending_nxt = 1'b0;
        latch_nxt   = 1'b0;
        lane_step   = 1'b0;
        lane_move   = 1'b0;
        lane_reload = 1'b0;
        enter_hit   = 1'b0;
        case (state)
            ST_PLAY: begin
                latch_nxt   = ~frame_tick & (hit_latch | (ob_pixel & chicken_pixel));
                pending_nxt = (move_pending & ~frame_tick) | btn_edge;
                if (frame_tick) begin
                    if (hit_latch) begin
                        // Collision wins over a pending move; the move is dropped
                        state_nxt   = ST_HIT;
                        cnt_nxt     = CNT_W'(FLASH_FRAMES);
                        pending_nxt = 1'b0;
                        enter_hit   = 1'b1;
                    end else begin
                        lane_step = 1'b1;
                        if (move_pending) begin
                            lane_move = 1'b1;
                            if (score != 8'hFF) begin
                                score_nxt = score + 8'd1;
                            end
                        end
                    end
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    if (flash_cnt <= CNT_W'(1)) begin
                        state_nxt = ST_RESTART;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = flash_cnt - CNT_W'(1);
                    end
                end
            end
            ST_RESTART: begin
                lane_reload = 1'b1;
                score_nxt   = '0;
                state_nxt   = ST_PLAY;
            end
            default: begin
                state_nxt = ST_PLAY;
            end
        endcase
    end

    // State, flags and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1        <= 1'b0;
            btn_s2        <= 1'b0;
            btn_d         <= 1'b0;
            state         <= ST_PLAY;
            flash_cnt     <= '0;
            score         <= '0;
            move_pending  <= 1'b0;
            hit_latch     <= 1'b0;
            ob_pixel      <= 1'b0;
            chicken_pixel <= 1'b0;
            collision     <= 1'b0;
            hit_flash     <= 1'b0;
        end else begin
            btn_s1        <= move_btn;
            btn_s2        <= btn_s1;
            btn_d         <= btn_s2;
            state         <= state_nxt;
            flash_cnt     <= cnt_nxt;
            score         <= score_nxt;
            move_pending  <= pending_nxt;
            hit_latch     <= latch_nxt;
            // Blank obstacles during RESTART so stale positions cannot latch a hit
            ob_pixel      <= display_on & (|lane_hit) & (state != ST_RESTART);
            chicken_pixel <= display_on & chicken_hit;
            collision     <= enter_hit;
            hit_flash     <= (state_nxt == ST_HIT);
        end
    end

endmodule

// File: tb/tb_obstacle_field.sv
// Randomised bench for obstacle_field with a frame-level reference model.
module tb_obstacle_field;

    localparam int NL        = 4;
    localparam int FRAME_LEN = 24;
    localparam int FLASH     = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       move_btn;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       ob_pixel;
    logic       chicken_pixel;
    logic       hit_flash;
    logic       collision;
    logic [7:0] score;
    logic [1:0] state;

    always #5 clk = ~clk;

    obstacle_field dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .move_btn      (move_btn),
        .hpos          (hpos),
        .vpos          (vpos),
        .display_on    (display_on),
        .ob_pixel      (ob_pixel),
        .chicken_pixel (chicken_pixel),
        .hit_flash     (hit_flash),
        .collision     (collision),
        .score         (score),
        .state         (state)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int   m_x [NL];
    int   m_y [NL];
    int   m_score, m_state, m_cnt, m_pend, m_latch;
    int   m_ob, m_ck, m_col, m_flash;
    int   b1, b2, b3;
    int   cyc;
    logic rst_req;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int lane_x(input int i);
        case (i)
            0:       return int'(dut.g_lane[0].u_lane.x_pos);
            1:       return int'(dut.g_lane[1].u_lane.x_pos);
            2:       return int'(dut.g_lane[2].u_lane.x_pos);
            default: return int'(dut.g_lane[3].u_lane.x_pos);
        endcase
    endfunction

    function automatic int lane_y(input int i);
        case (i)
            0:       return int'(dut.g_lane[0].u_lane.y_pos);
            1:       return int'(dut.g_lane[1].u_lane.y_pos);
            2:       return int'(dut.g_lane[2].u_lane.y_pos);
            default: return int'(dut.g_lane[3].u_lane.y_pos);
        endcase
    endfunction

    function automatic int covered(input int h, input int v);
        for (int i = 0; i < NL; i++) begin
            if (h >= m_x[i] && h < m_x[i] + 50 && v >= m_y[i] && v < m_y[i] + 30) return 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_x[i] = (i * 160) % 640;
            m_y[i] = 32 + i * 90;
        end
        m_score = 0; m_state = 0; m_cnt = 0; m_pend = 0; m_latch = 0;
        m_ob = 0; m_ck = 0; m_col = 0; m_flash = 0;
        b1 = 0; b2 = 0; b3 = 0;
    endtask

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_step();
        int nob, nck, edge_seen, ncol, s, h, v;
        h   = int'(hpos);
        v   = int'(vpos);
        nob = (display_on && m_state != 2 && covered(h, v) != 0) ? 1 : 0;
        nck = (display_on && h >= 310 && h <= 339 && v >= 400 && v <= 439) ? 1 : 0;
        edge_seen = (b2 == 1 && b3 == 0) ? 1 : 0;
        b3 = b2; b2 = b1; b1 = int'(move_btn);
        ncol = 0;
        case (m_state)
            0: begin
                if (frame_tick && m_latch != 0) begin
                    m_state = 1; m_cnt = FLASH; m_pend = 0; ncol = 1;
                end else if (frame_tick) begin
                    s = 1 + m_score / 8;
                    if (s > 4) s = 4;
                    for (int i = 0; i < NL; i++) begin
                        if (i % 2 == 0) m_x[i] = (m_x[i] + s) % 640;
                        else            m_x[i] = (m_x[i] - s + 640) % 640;
                    end
                    if (m_pend != 0) begin
                        for (int i = 0; i < NL; i++) m_y[i] = (m_y[i] + 10) % 480;
                        if (m_score < 255) m_score++;
                    end
                    m_pend = edge_seen;
                end else begin
                    m_pend = (m_pend != 0 || edge_seen != 0) ? 1 : 0;
                end
                m_latch = (!frame_tick && (m_latch != 0 || (m_ob != 0 && m_ck != 0))) ? 1 : 0;
            end
            1: begin
                if (frame_tick) begin
                    m_cnt--;
                    if (m_cnt == 0) m_state = 2;
                end
            end
            default: begin
                for (int i = 0; i < NL; i++) begin
                    m_x[i] = (i * 160) % 640;
                    m_y[i] = 32 + i * 90;
                end
                m_score = 0; m_state = 0; m_pend = 0; m_latch = 0;
            end
        endcase
        m_ob = nob; m_ck = nck; m_col = ncol;
        m_flash = (m_state == 1) ? 1 : 0;
    endtask

    task automatic compare_all();
        check_eq("ob_pixel", int'(ob_pixel), m_ob);
        check_eq("chicken_pixel", int'(chicken_pixel), m_ck);
        check_eq("collision", int'(collision), m_col);
        check_eq("hit_flash", int'(hit_flash), m_flash);
        check_eq("score", int'(score), m_score);
        check_eq("state", int'(state), m_state);
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("x%0d", i), lane_x(i), m_x[i]);
            check_eq($sformatf("y%0d", i), lane_y(i), m_y[i]);
        end
    endtask

    // bm: 0 idle, 1 one press, 2 random, 3 three presses, 4 held high
    // pm: 0 display off, 1 random pixel, 2 pixel near the chicken
    task automatic one_cycle(input int bm, input int pm);
        int phase;
        @(negedge clk);
        compare_all();
        phase      = cyc % FRAME_LEN;
        reset      = rst_req;
        frame_tick = (phase == 0);
        case (bm)
            1:       move_btn = (phase >= 4 && phase < 8);
            2:       move_btn = 1'($urandom_range(0, 1));
            3:       move_btn = (phase == 4 || phase == 6 || phase == 8);
            4:       move_btn = 1'b1;
            default: move_btn = 1'b0;
        endcase
        case (pm)
            1: begin
                display_on = 1'($urandom_range(0, 1));
                hpos = 10'($urandom_range(0, 639));
                vpos = 10'($urandom_range(0, 479));
            end
            2: begin
                display_on = 1'b1;
                hpos = 10'($urandom_range(300, 349));
                vpos = 10'($urandom_range(390, 449));
            end
            default: begin
                display_on = 1'b0;
                hpos = 10'($urandom_range(0, 639));
                vpos = 10'($urandom_range(0, 479));
            end
        endcase
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        cyc++;
    endtask

    task automatic run_frames(input int n, input int bm, input int pm);
        repeat (n * FRAME_LEN) one_cycle(bm, pm);
    endtask

    task automatic run_until_state(input int target, input int bound, input int bm,
                                   input int pm, input string tag);
        int k = 0;
        while (m_state != target && k < bound) begin
            one_cycle(bm, pm);
            k++;
        end
        if (m_state != target) check_eq({tag, "_timeout"}, m_state, target);
    endtask

    task automatic run_until_latch(input int bound, input int bm, input int pm);
        int k = 0;
        while (m_latch == 0 && k < bound) begin
            one_cycle(bm, pm);
            k++;
        end
        if (m_latch == 0) check_eq("latch_timeout", m_latch, 1);
    endtask

    // Async reset in the middle of a clock period, checked before any edge
    task automatic do_reset(input string tag);
        #2;
        reset   = 1'b1;
        rst_req = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < NL; i++) begin
            check_eq({tag, $sformatf("_x%0d", i)}, lane_x(i), i * 160);
            check_eq({tag, $sformatf("_y%0d", i)}, lane_y(i), 32 + i * 90);
        end
        check_eq({tag, "_score"}, int'(score), 0);
        check_eq({tag, "_state"}, int'(state), 0);
        check_eq({tag, "_ob"}, int'(ob_pixel), 0);
        check_eq({tag, "_ck"}, int'(chicken_pixel), 0);
        check_eq({tag, "_flash"}, int'(hit_flash), 0);
        check_eq({tag, "_col"}, int'(collision), 0);
        repeat (2) one_cycle(0, 0);
        rst_req = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xb;
        reset = 1'b1; rst_req = 1'b1; frame_tick = 1'b0; move_btn = 1'b0;
        hpos = '0; vpos = '0; display_on = 1'b0; cyc = 0;
        model_reset();
        repeat (3) one_cycle(0, 0);
        rst_req = 1'b0;
        cyc = 0;
        run_frames(5, 2, 1);

        // Reset mid-frame
        repeat (7) one_cycle(2, 1);
        do_reset("rst_mid");

        // Three frames, no button
        run_frames(3, 0, 0);
        #1;
        check_eq("t3_x0", lane_x(0), 3);
        check_eq("t3_x1", lane_x(1), 157);
        check_eq("t3_x2", lane_x(2), 323);
        check_eq("t3_x3", lane_x(3), 477);
        check_eq("t3_y0", lane_y(0), 32);

        // Full wrap after 640 frames
        run_frames(637, 0, 0);
        #1;
        for (int i = 0; i < NL; i++) check_eq($sformatf("wrap_x%0d", i), lane_x(i), i * 160);

        // Three edges in one frame merge into one move
        run_frames(1, 3, 0);
        run_frames(1, 0, 0);
        #1;
        check_eq("merge_y0", lane_y(0), 42);
        check_eq("merge_score", int'(score), 1);

        // Score 8 gives speed 2
        run_frames(7, 1, 0);
        run_frames(1, 0, 0);
        #1;
        check_eq("score8", int'(score), 8);
        xb = m_x[0];
        run_frames(1, 0, 0);
        #1;
        check_eq("speed2_x0", lane_x(0), (xb + 2) % 640);

        // Saturation
        run_frames(300, 1, 0);
        run_frames(1, 0, 0);
        #1;
        check_eq("score_sat", int'(score), 255);

        // Collision with lane 3 pushed down to y=392
        do_reset("rst_pre_hit");
        run_frames(9, 1, 0);
        run_frames(1, 0, 0);
        #1;
        check_eq("hit_setup_y3", lane_y(3), 392);
        check_eq("hit_setup_score", int'(score), 9);
        run_until_state(1, 300 * FRAME_LEN, 0, 2, "enter_hit");
        #1;
        check_eq("hit_col", int'(collision), 1);
        check_eq("hit_state", int'(state), 1);
        check_eq("hit_flash_on", int'(hit_flash), 1);
        run_until_state(2, (FLASH + 2) * FRAME_LEN, 1, 2, "enter_restart");
        #1;
        check_eq("restart_state", int'(state), 2);
        check_eq("restart_flash", int'(hit_flash), 0);
        run_until_state(0, 2, 1, 2, "restart_to_play");
        #1;
        check_eq("play_score", int'(score), 0);
        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("play_x%0d", i), lane_x(i), i * 160);
            check_eq($sformatf("play_y%0d", i), lane_y(i), 32 + i * 90);
        end

        // Collision and button press in the same frame
        do_reset("rst_pre_hit2");
        run_frames(9, 1, 0);
        run_frames(1, 0, 0);
        run_until_latch(300 * FRAME_LEN, 0, 2);
        run_until_state(1, 2 * FRAME_LEN, 4, 2, "enter_hit2");
        #1;
        check_eq("hit2_state", int'(state), 1);
        check_eq("hit2_score", int'(score), 9);
        check_eq("hit2_y3", lane_y(3), 392);

        // Reset while in HIT
        run_frames(3, 1, 2);
        do_reset("rst_in_hit");

        // Free-running random play
        run_frames(200, 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
